// File: rtl/pmod_keypad_if.sv
// Key-press request handshake and press status between a controller and the keypad emulator.
interface pmod_keypad_if;
  localparam int unsigned KEY_W   = 4;
  localparam int unsigned COUNT_W = 16;

  logic [KEY_W-1:0]   key_in;
  logic               key_valid;
  logic               key_ready;
  logic               pressed;
  logic               done;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output key_in, key_valid,
    input  key_ready, pressed, done, press_count
  );

  modport slave (
    input  key_in, key_valid,
    output key_ready, pressed, done, press_count
  );
endinterface

// File: rtl/pmod_keypad_emulator.sv
// Responder side of a column-scan keypad: answers the scanner's active-low column drive
// with active-low row lines for one injected key, held and then released for set times.
module pmod_keypad_emulator #(
  parameter int unsigned HOLD_TICKS = 10000000,
  parameter int unsigned GAP_TICKS  = 5000000,
  parameter int unsigned CNT_BITS   = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   col,
  output logic [3:0]   row,
  pmod_keypad_if.slave bus
);
  localparam int unsigned LINE_W  = 4;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic [LINE_W-1:0]   key_q;
  logic [LINE_W-1:0]   col_m;
  logic [LINE_W-1:0]   col_s;
  logic                ready_q;
  logic                pressed_q;
  logic                done_q;
  logic [COUNT_W-1:0]  press_cnt;
  logic [1:0]          col_idx;
  logic [1:0]          row_idx;

  // Keypad layout: rows 123A/456B/789C/0FED top to bottom, columns left to right map to bit 3..0.
  function automatic logic [1:0] key_col_bit(input logic [3:0] k);
    case (k)
      4'h1, 4'h4, 4'h7, 4'h0: key_col_bit = 2'd3;
      4'h2, 4'h5, 4'h8, 4'hF: key_col_bit = 2'd2;
      4'h3, 4'h6, 4'h9, 4'hE: key_col_bit = 2'd1;
      default:                key_col_bit = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] key_row_bit(input logic [3:0] k);
    case (k)
      4'h1, 4'h2, 4'h3, 4'hA: key_row_bit = 2'd3;
      4'h4, 4'h5, 4'h6, 4'hB: key_row_bit = 2'd2;
      4'h7, 4'h8, 4'h9, 4'hC: key_row_bit = 2'd1;
      default:                key_row_bit = 2'd0;
    endcase
  endfunction

  always_comb begin
    col_idx = key_col_bit(key_q);
    row_idx = key_row_bit(key_q);
  end

  // Column synchronizer and registered row response; other column bits are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      row   <= 4'hF;
    end else begin
      col_m <= col;
      col_s <= col_m;
      if (pressed_q && !col_s[col_idx]) begin
        row <= ~(LINE_W'(1) << row_idx);
      end else begin
        row <= 4'hF;
      end
    end
  end

  // Press sequencer: accept a request, hold for HOLD_TICKS, force release for GAP_TICKS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_q     <= '0;
      ready_q   <= 1'b0;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      press_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.key_valid && ready_q) begin
            key_q     <= bus.key_in;
            cnt       <= CNT_BITS'(HOLD_TICKS - 1);
            state     <= PRESS;
            ready_q   <= 1'b0;
            pressed_q <= 1'b1;
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            cnt       <= CNT_BITS'(GAP_TICKS - 1);
            state     <= RELEASE;
            pressed_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            done_q    <= 1'b1;
            press_cnt <= press_cnt + COUNT_W'(1);
            state     <= IDLE;
            ready_q   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_BITS'(1);
          end
        end
        default: begin
          state     <= IDLE;
          ready_q   <= 1'b0;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_ready   = ready_q;
  assign bus.pressed     = pressed_q;
  assign bus.done        = done_q;
  assign bus.press_count = press_cnt;
endmodule
